// File: rtl/ffd_reg_arbiter_pkg.sv
// Shared definitions for the round-robin register write arbiter:
// FSM state encoding and the index-width helper.
package ffd_reg_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_ACK   = 2'd2
   } state_e;

   // Bits needed to index n items (n >= 2).
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ffd.sv
// Team storage cell: one D flip-flop with synchronous active-high reset
// and a load enable; holds its value when enable is low.
module ffd (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= 1'b0;
      end else if (en) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/ffd_reg_arbiter_rr_picker.sv
// Combinational round-robin search: first set request bit at or above
// ptr, wrapping past NREQ-1 back to 0.
module rr_picker
   import ffd_reg_arbiter_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]        req,
   input  logic [clog2(NREQ)-1:0] ptr,
   output logic                   valid,
   output logic [clog2(NREQ)-1:0] idx
);

   localparam int OW = clog2(NREQ);

   // Scan offsets from farthest to nearest so the nearest hit is kept.
   always_comb begin : pick
      int c;
      valid = 1'b0;
      idx   = '0;
      c     = 0;
      for (int off = NREQ - 1; off >= 0; off--) begin
         c = (int'(ptr) + off) % NREQ;
         if (req[c]) begin
            valid = 1'b1;
            idx   = c[OW-1:0];
         end else begin
            valid = valid;
         end
      end
   end

endmodule

// File: rtl/ffd_reg_arbiter.sv
// Round-robin write arbiter for one shared register built from ffd cells:
// latch a winner, write it through the shared enable, pulse its gnt.
module ffd_reg_arbiter
   import ffd_reg_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*WIDTH-1:0]  wdata,
   output logic [NREQ-1:0]        gnt,
   output logic                   busy,
   output logic [clog2(NREQ)-1:0] owner,
   output logic [WIDTH-1:0]       q
);

   localparam int            OW   = clog2(NREQ);
   localparam logic [OW-1:0] LAST = OW'(NREQ - 1);

   state_e            state_q, state_d;
   logic [OW-1:0]     owner_q, owner_d;
   logic [OW-1:0]     ptr_q, ptr_d;
   logic [WIDTH-1:0]  hold_q, hold_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              busy_q, busy_d;
   logic              pick_valid_s;
   logic [OW-1:0]     pick_idx_s;
   logic              wr_en_s;

   rr_picker #(
      .NREQ (NREQ)
   ) u_rr_picker (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid_s),
      .idx   (pick_idx_s)
   );

   // Next-state, latch and grant decisions.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid_s) begin
               state_d = ST_WRITE;
               owner_d = pick_idx_s;
               hold_d  = wdata[int'(pick_idx_s)*WIDTH +: WIDTH];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            state_d = ST_ACK;
            gnt_d   = NREQ'(1'b1) << owner_q;
         end
         ST_ACK: begin
            state_d = ST_IDLE;
            ptr_d   = (owner_q == LAST) ? '0 : owner_q + OW'(1);
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and control registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
      end
   end

   assign wr_en_s = (state_q == ST_WRITE);

   // The shared register: one ffd per bit, common enable and reset.
   for (genvar i = 0; i < WIDTH; i++) begin : g_reg
      ffd u_ffd (
         .clk (clk),
         .rst (rst),
         .en  (wr_en_s),
         .d   (hold_q[i]),
         .q   (q[i])
      );
   end

   assign gnt   = gnt_q;
   assign busy  = busy_q;
   assign owner = owner_q;

endmodule

// File: tb/tb_ffd_reg_arbiter.sv
// Scoreboard bench for ffd_reg_arbiter: directed scenarios followed by
// random requesters, checked against a transaction-level reference model.
module tb_ffd_reg_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic [1:0]            owner;
   logic [WIDTH-1:0]      q;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int               who;
      logic [WIDTH-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   gnt_log[$];

   // Reference model: write cycle = latch, write, ack; then idle again.
   int               m_ptr   = 0;
   int               m_phase = 0;
   int               m_owner = 0;
   logic [WIDTH-1:0] m_hold  = '0;
   logic [WIDTH-1:0] m_q     = '0;

   ffd_reg_arbiter #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .busy  (busy),
      .owner (owner),
      .q     (q)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [NREQ-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Model update on each rising edge.
   initial forever begin
      bit found;
      int w;
      @(posedge clk);
      if (rst) begin
         m_ptr = 0; m_phase = 0; m_owner = 0; m_q = '0;
         sb.delete();
      end else if (m_phase == 0) begin
         found = 1'b0;
         w = 0;
         for (int o = 0; o < NREQ; o++) begin
            int c;
            c = (m_ptr + o) % NREQ;
            if (!found && req[c]) begin
               found = 1'b1;
               w = c;
            end
         end
         if (found) begin
            m_owner = w;
            m_hold  = wdata[w*WIDTH +: WIDTH];
            sb.push_back('{w, m_hold});
            m_phase = 2;
         end
      end else if (m_phase == 2) begin
         m_q = m_hold;
         m_phase = 1;
      end else begin
         m_ptr = (m_owner + 1) % NREQ;
         m_phase = 0;
      end
   end

   // Monitor: per-cycle outputs plus scoreboard pop on every gnt pulse.
   initial forever begin
      exp_t e;
      @(negedge clk);
      check("q", 32'(q), 32'(m_q));
      check("busy", 32'(busy), 32'(m_phase != 0));
      check("owner", 32'(owner), 32'(m_owner));
      check("gnt", 32'(gnt), (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
      if (gnt != '0) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_gnt actual=%0h expected=none at %0t", gnt, $time);
         end else begin
            e = sb.pop_front();
            check("sb_gnt", 32'(gnt), 32'd1 << e.who);
            check("sb_data", 32'(q), 32'(e.data));
         end
         gnt_log.push_back(idx_of(gnt));
      end
   end

   // Requesters drop req in their gnt cycle.
   task automatic tick();
      @(negedge clk);
      req = req & ~gnt;
   endtask

   task automatic set_wd(input int i, input logic [WIDTH-1:0] v);
      wdata[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      tick();
      while ((req != '0 || busy) && n < limit) begin
         tick();
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL wait_idle timeout actual=%0d expected<%0d", n, limit);
      end
   endtask

   initial begin
      rst   = 1'b1;
      req   = 4'b1111;
      wdata = {8'h13, 8'h12, 8'h11, 8'h10};
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Contention: strict order 0,1,2,3.
      gnt_log.delete();
      wait_idle(60);
      check("contention_count", 32'(gnt_log.size()), 32'd4);
      for (int i = 0; i < gnt_log.size() && i < 4; i++)
         check("contention_order", 32'(gnt_log[i]), 32'(i));
      check("contention_q", 32'(q), 32'h13);

      // Single write by requester 2.
      req = 4'b0100;
      set_wd(2, 8'hA5);
      wait_idle(20);
      check("single_q", 32'(q), 32'hA5);
      check("single_owner", 32'(owner), 32'd2);

      // Pointer at 3: requester 3 first, then 0; pointer returns to 1.
      gnt_log.delete();
      req = 4'b1001;
      set_wd(0, 8'h55);
      set_wd(3, 8'h66);
      wait_idle(30);
      check("wrap_count", 32'(gnt_log.size()), 32'd2);
      if (gnt_log.size() == 2) begin
         check("wrap_first", 32'(gnt_log[0]), 32'd3);
         check("wrap_second", 32'(gnt_log[1]), 32'd0);
      end
      gnt_log.delete();
      req = 4'b0101;
      set_wd(0, 8'h01);
      set_wd(2, 8'h02);
      wait_idle(30);
      check("ptr_after_wrap", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 32'd2);

      // Data stability after the latch edge.
      gnt_log.delete();
      req = 4'b0010;
      set_wd(1, 8'h3C);
      tick();
      set_wd(1, 8'hFF);
      req[1] = 1'b0;
      wait_idle(20);
      check("stable_q", 32'(q), 32'h3C);
      check("stable_gnt", 32'(gnt_log.size() == 1 && gnt_log[0] == 1), 32'd1);

      // Reset during WRITE: dropped write, then the held request is served.
      gnt_log.delete();
      req = 4'b0100;
      set_wd(2, 8'h77);
      tick();
      rst = 1'b1;
      tick();
      check("midrst_q", 32'(q), 32'h0);
      check("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      wait_idle(20);
      check("midrst_served", 32'(gnt_log.size()), 32'd1);
      check("midrst_q_after", 32'(q), 32'h77);

      // Random requesters with occasional resets.
      for (int cyc = 0; cyc < 600; cyc++) begin
         tick();
         rst = ($urandom_range(99) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && !gnt[i] && $urandom_range(3) == 0) begin
               set_wd(i, WIDTH'($urandom));
               req[i] = 1'b1;
            end
         end
      end
      rst = 1'b0;
      wait_idle(200);
      check("sb_drain", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
